tl_ul_ram_responder: RTL and testbench

- TileLink-UL responder (slave) endpoint: accepts A-channel Get/PutFullData/PutPartialData and returns D-channel AccessAckData/AccessAck from a local word-addressed RAM.
- It is the active counterpart to the passive TL monitor/assert wrappers. It terminates a single-beat TL-UL port on the E21 testbench fabric.
- One request is in flight at a time, with an optional fixed wait-state delay.

---
 rtl/tl_ul_ram_responder.sv | 181 ++++++++++++++++++
 tb/tb_tl_ul_ram_responder.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL single-beat responder backed by a local word-addressed RAM.
// Optional per-byte even parity storage is enabled with `define TL_RAM_PARITY_EN.
module tl_ul_ram_responder #(
  parameter int                ADDR_W      = 30,
  parameter int                DATA_W      = 32,
  parameter int                SRC_W       = 2,
  parameter int                SIZE_W      = 3,
  parameter int                DEPTH_LOG2  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 30'h0200_0000,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                clock,
  input  logic                reset,
`ifdef TL_RAM_PARITY_EN
  input  logic                parity_inject,
`endif
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SRC_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SRC_W-1:0]    d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_corrupt
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam int         TAG_LSB   = DEPTH_LOG2 + 2;
  localparam int         LANES     = DATA_W / 8;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;

  logic a_fire, d_fire;
  logic hit, aligned, is_get, is_put, denied, rd_corrupt;
  logic [1:0] align_mask;
  logic [DEPTH_LOG2-1:0] index;
  logic [DATA_W-1:0] rd_word;
  logic unused_inputs;

  logic [DATA_W-1:0] mem [DEPTH];

  assign unused_inputs = ^a_param;

  assign d_valid = (state == RESP);
  assign a_ready = (state == IDLE) || ((state == RESP) && (WAIT_CYCLES == 0) && d_ready);
  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;

  // Address decode and request legality; anything failing here is answered with d_denied.
  assign hit   = (a_address[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
  assign index = a_address[TAG_LSB-1:2];

  always_comb begin
    align_mask = 2'b00;
    if (a_size == SIZE_W'(1))
      align_mask = 2'b01;
    else if (a_size == SIZE_W'(2))
      align_mask = 2'b11;
  end

  assign aligned = ((a_address[1:0] & align_mask) == 2'b00);
  assign is_get  = (a_opcode == 3'd4);
  assign is_put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign denied  = !hit || (a_size > SIZE_W'(2)) || !aligned || !(is_get || is_put) ||
                   (is_put && a_corrupt);
  assign rd_word = mem[index];

  always_ff @(posedge clock) begin
    if (a_fire && is_put && !denied) begin
      for (int b = 0; b < LANES; b++) begin
        if (a_mask[b])
          mem[index][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

`ifdef TL_RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] par_bad;

  always_ff @(posedge clock) begin
    if (a_fire && is_put && !denied) begin
      for (int b = 0; b < LANES; b++) begin
        if (a_mask[b])
          par_mem[index][b] <= (^a_data[8*b +: 8]) ^ parity_inject;
      end
    end
  end

  always_comb begin
    par_bad = '0;
    for (int b = 0; b < LANES; b++)
      par_bad[b] = a_mask[b] & ((^rd_word[8*b +: 8]) ^ par_mem[index][b]);
  end

  assign rd_corrupt = is_get && (denied || (|par_bad));
`else
  assign rd_corrupt = is_get && denied;
`endif

  // Next-state logic; WAIT_CYCLES==0 skips WAIT and lets RESP accept back-to-back.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (a_fire) begin
          wait_cnt_nxt = WAIT_INIT;
          if (WAIT_CYCLES > 0)
            state_nxt = WAIT;
          else
            state_nxt = RESP;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0)
          state_nxt = RESP;
        else
          wait_cnt_nxt = wait_cnt - 4'd1;
      end
      RESP: begin
        if (d_fire) begin
          if (a_fire) begin
            wait_cnt_nxt = WAIT_INIT;
            if (WAIT_CYCLES > 0)
              state_nxt = WAIT;
            else
              state_nxt = RESP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      d_opcode  <= 3'd0;
      d_size    <= '0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (a_fire) begin
        d_opcode  <= is_get ? 3'd1 : 3'd0;
        d_size    <= a_size;
        d_source  <= a_source;
        d_denied  <= denied;
        d_data    <= (is_get && !denied) ? rd_word : '0;
        d_corrupt <= rd_corrupt;
      end
    end
  end

  assign d_param = 2'd0;
  assign d_sink  = 1'b0;

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Self-checking bench: instance 0 has no wait states, instance 1 has WAIT_CYCLES=3.
// Both use base 0x0800_0000 so the byte addresses of the directed scenarios decode as hits.
module tb_tl_ul_ram_responder;

  localparam logic [29:0] BASE = 30'h0800_0000;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        a_valid   [2];
  logic        a_ready   [2];
  logic [2:0]  a_opcode  [2];
  logic [2:0]  a_param   [2];
  logic [2:0]  a_size    [2];
  logic [1:0]  a_source  [2];
  logic [29:0] a_address [2];
  logic [3:0]  a_mask    [2];
  logic [31:0] a_data    [2];
  logic        a_corrupt [2];
  logic        d_valid   [2];
  logic        d_ready   [2];
  logic [2:0]  d_opcode  [2];
  logic [1:0]  d_param   [2];
  logic [2:0]  d_size    [2];
  logic [1:0]  d_source  [2];
  logic        d_sink    [2];
  logic        d_denied  [2];
  logic [31:0] d_data    [2];
  logic        d_corrupt [2];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [256];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tl_ul_ram_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(g * 3)) dut (
      .clock(clock), .reset(reset),
`ifdef TL_RAM_PARITY_EN
      .parity_inject(1'b0),
`endif
      .a_valid(a_valid[g]), .a_ready(a_ready[g]), .a_opcode(a_opcode[g]),
      .a_param(a_param[g]), .a_size(a_size[g]), .a_source(a_source[g]),
      .a_address(a_address[g]), .a_mask(a_mask[g]), .a_data(a_data[g]),
      .a_corrupt(a_corrupt[g]), .d_valid(d_valid[g]), .d_ready(d_ready[g]),
      .d_opcode(d_opcode[g]), .d_param(d_param[g]), .d_size(d_size[g]),
      .d_source(d_source[g]), .d_sink(d_sink[g]), .d_denied(d_denied[g]),
      .d_data(d_data[g]), .d_corrupt(d_corrupt[g])
    );
  end

  function automatic resp_t observe(input int inst);
    resp_t r;
    r = '{d_opcode[inst], d_param[inst], d_size[inst], d_source[inst], d_sink[inst],
          d_denied[inst], d_data[inst], d_corrupt[inst]};
    return r;
  endfunction

  // Reference model for instance 0: legality from the protocol rules, RAM as a plain array.
  task automatic model(input logic [2:0] op, input logic [29:0] addr, input logic [2:0] size,
                       input logic [1:0] src, input logic [3:0] mask, input logic [31:0] data,
                       input logic corr, output resp_t r);
    logic get, put, deny;
    int idx;
    get  = (op == 3'd4);
    put  = (op == 3'd0) || (op == 3'd1);
    deny = ((addr >> 10) != (BASE >> 10)) || (size > 3'd2) || ((addr % (1 << size)) != 0) ||
           !(get || put) || (put && corr);
    idx  = int'((addr >> 2) % 256);
    r        = '0;
    r.opcode = get ? 3'd1 : 3'd0;
    r.size   = size;
    r.source = src;
    r.denied = deny;
    if (get) begin
      r.corrupt = deny;
      if (!deny) r.data = ref_mem[idx];
    end
    if (put && !deny) begin
      for (int k = 0; k < 4; k++)
        if (mask[k]) ref_mem[idx][8*k +: 8] = data[8*k +: 8];
    end
  endtask

  // One request with d_ready high; called just after a rising edge, returns just after one.
  task automatic do_txn(input int inst, input logic [2:0] op, input logic [29:0] addr,
                        input logic [2:0] size, input logic [1:0] src, input logic [3:0] mask,
                        input logic [31:0] data, input logic corr, output resp_t r, output int lat);
    int n;
    d_ready[inst]   = 1'b1;
    a_opcode[inst]  = op;
    a_param[inst]   = 3'($urandom_range(0, 7));
    a_address[inst] = addr;
    a_size[inst]    = size;
    a_source[inst]  = src;
    a_mask[inst]    = mask;
    a_data[inst]    = data;
    a_corrupt[inst] = corr;
    a_valid[inst]   = 1'b1;
    n = 0;
    @(negedge clock);
    while (!a_ready[inst] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("[TB] FAIL a_ready_timeout inst=%0d got a_ready=0 need 1", inst);
    end
    @(posedge clock);
    #1 a_valid[inst] = 1'b0;
    lat = 0;
    r   = '1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      if (d_valid[inst]) begin
        lat = c;
        r   = observe(inst);
        break;
      end
    end
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("[TB] FAIL d_valid_timeout inst=%0d got d_valid=0 need 1", inst);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (d_valid[i] !== 1'b0) begin
        n_err++; $display("[TB] FAIL reset_d_valid inst=%0d got %b need 0", i, d_valid[i]);
      end
      n_vec++;
      if (observe(i) !== resp_t'(0)) begin
        n_err++; $display("[TB] FAIL reset_d_regs inst=%0d got %h need 0", i, observe(i));
      end
    end
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (a_ready[i] !== 1'b1) begin
        n_err++; $display("[TB] FAIL reset_a_ready inst=%0d got %b need 1", i, a_ready[i]);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_put_get();
    resp_t e, r;
    int lat;
    model(3'd0, BASE + 30'h10, 3'd2, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, e);
    do_txn(0, 3'd0, BASE + 30'h10, 3'd2, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, r, lat);
    n_vec++;
    if (r !== e) begin n_err++; $display("[TB] FAIL putfull_resp got %h need %h", r, e); end
    n_vec++;
    if (lat !== 1) begin n_err++; $display("[TB] FAIL putfull_latency got %0d need 1", lat); end
    model(3'd4, BASE + 30'h10, 3'd2, 2'd1, 4'hF, 32'h0, 1'b0, e);
    do_txn(0, 3'd4, BASE + 30'h10, 3'd2, 2'd1, 4'hF, 32'h0, 1'b0, r, lat);
    n_vec++;
    if (r !== e) begin n_err++; $display("[TB] FAIL get_resp got %h need %h", r, e); end
    n_vec++;
    if (r.data !== 32'hDEADBEEF) begin
      n_err++; $display("[TB] FAIL get_data got %h need deadbeef", r.data);
    end
    model(3'd1, BASE + 30'h10, 3'd2, 2'd0, 4'h5, 32'h11223344, 1'b0, e);
    do_txn(0, 3'd1, BASE + 30'h10, 3'd2, 2'd0, 4'h5, 32'h11223344, 1'b0, r, lat);
    n_vec++;
    if (r !== e) begin n_err++; $display("[TB] FAIL putpartial_resp got %h need %h", r, e); end
    model(3'd4, BASE + 30'h10, 3'd2, 2'd3, 4'hF, 32'h0, 1'b0, e);
    do_txn(0, 3'd4, BASE + 30'h10, 3'd2, 2'd3, 4'hF, 32'h0, 1'b0, r, lat);
    n_vec++;
    if (r.data !== 32'hDE22BE44 || r !== e) begin
      n_err++; $display("[TB] FAIL partial_merge got %h need data de22be44 resp %h", r, e);
    end
  endtask

  task automatic test_denied();
    resp_t e, r;
    int lat;
    logic [2:0] op, size;
    logic [29:0] addr;
    logic [3:0] mask;
    logic [31:0] data;
    logic corr, want_deny;
    for (int i = 0; i < 6; i++) begin
      op = 3'd4; addr = BASE + 30'h10; size = 3'd2; mask = 4'hF; data = 32'h0; corr = 1'b0;
      want_deny = 1'b1;
      case (i)
        0: addr = 30'h0900_0000;
        1: addr = BASE + 30'h2;
        2: op = 3'd2;
        3: size = 3'd3;
        4: begin op = 3'd0; data = 32'h5555_5555; corr = 1'b1; end
        default: begin op = 3'd1; mask = 4'h0; data = 32'h9999_9999; want_deny = 1'b0; end
      endcase
      model(op, addr, size, 2'(i), mask, data, corr, e);
      do_txn(0, op, addr, size, 2'(i), mask, data, corr, r, lat);
      n_vec++;
      if (r !== e) begin n_err++; $display("[TB] FAIL denied_resp%0d got %h need %h", i, r, e); end
      n_vec++;
      if (r.denied !== want_deny) begin
        n_err++; $display("[TB] FAIL denied_flag%0d got %b need %b", i, r.denied, want_deny);
      end
    end
    do_txn(0, 3'd4, BASE + 30'h10, 3'd2, 2'd0, 4'hF, 32'h0, 1'b0, r, lat);
    n_vec++;
    if (r.data !== 32'hDE22BE44 || r.denied !== 1'b0) begin
      n_err++; $display("[TB] FAIL denied_no_write got %h need data de22be44", r);
    end
  endtask

  task automatic test_wait_states();
    resp_t r, e;
    int lat;
    do_txn(1, 3'd0, BASE + 30'h20, 3'd2, 2'd3, 4'hF, 32'hCAFEF00D, 1'b0, r, lat);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("[TB] FAIL wait_put_latency got %0d need 4", lat); end
    e = '{3'd1, 2'd0, 3'd2, 2'd3, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0};
    d_ready[1] = 1'b0;
    a_opcode[1] = 3'd4; a_address[1] = BASE + 30'h20; a_size[1] = 3'd2;
    a_source[1] = 2'd3; a_mask[1] = 4'hF; a_data[1] = 32'h0; a_corrupt[1] = 1'b0;
    a_valid[1] = 1'b1;
    @(negedge clock);
    n_vec++;
    if (a_ready[1] !== 1'b1) begin n_err++; $display("[TB] FAIL wait_idle_ready got %b need 1", a_ready[1]); end
    @(posedge clock);
    #1 a_valid[1] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      n_vec++;
      if (a_ready[1] !== 1'b0) begin
        n_err++; $display("[TB] FAIL wait_a_ready cycle=%0d got %b need 0", c, a_ready[1]);
      end
      if (d_valid[1]) begin lat = c; break; end
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("[TB] FAIL wait_get_latency got %0d need 4", lat); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      n_vec++;
      if (d_valid[1] !== 1'b1 || observe(1) !== e || a_ready[1] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL wait_hold%0d got v=%b r=%b d=%h need v=1 r=0 d=%h",
                 k, d_valid[1], a_ready[1], observe(1), e);
      end
    end
    @(posedge clock);
    #1 d_ready[1] = 1'b1;
    @(negedge clock);
    n_vec++;
    if (d_valid[1] !== 1'b1 || observe(1) !== e) begin
      n_err++; $display("[TB] FAIL wait_release got v=%b d=%h need v=1 d=%h", d_valid[1], observe(1), e);
    end
    @(posedge clock); #1;
    @(negedge clock);
    n_vec++;
    if (d_valid[1] !== 1'b0 || a_ready[1] !== 1'b1) begin
      n_err++; $display("[TB] FAIL wait_done got v=%b r=%b need v=0 r=1", d_valid[1], a_ready[1]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    resp_t e[4];
    resp_t r;
    int lat;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      model(3'd0, BASE + 30'(32 + 4 * k), 3'd2, 2'd0, 4'hF, w, 1'b0, r);
      do_txn(0, 3'd0, BASE + 30'(32 + 4 * k), 3'd2, 2'd0, 4'hF, w, 1'b0, r, lat);
    end
    for (int k = 0; k < 4; k++)
      model(3'd4, BASE + 30'(32 + 4 * k), 3'd2, 2'(k), 4'hF, 32'h0, 1'b0, e[k]);
    d_ready[0] = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) begin
        a_opcode[0] = 3'd4; a_address[0] = BASE + 30'(32 + 4 * c); a_size[0] = 3'd2;
        a_source[0] = 2'(c); a_mask[0] = 4'hF; a_corrupt[0] = 1'b0; a_valid[0] = 1'b1;
      end else begin
        a_valid[0] = 1'b0;
      end
      @(negedge clock);
      if (c < 4) begin
        n_vec++;
        if (a_ready[0] !== 1'b1) begin
          n_err++; $display("[TB] FAIL b2b_a_ready%0d got %b need 1", c, a_ready[0]);
        end
      end
      if (c >= 1) begin
        n_vec++;
        if (d_valid[0] !== 1'b1 || observe(0) !== e[c-1]) begin
          n_err++; $display("[TB] FAIL b2b_resp%0d got v=%b d=%h need v=1 d=%h",
                            c - 1, d_valid[0], observe(0), e[c-1]);
        end
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    n_vec++;
    if (d_valid[0] !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_drain got %b need 0", d_valid[0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    resp_t r;
    int lat;
    d_ready[0] = 1'b0;
    a_opcode[0] = 3'd4; a_address[0] = BASE + 30'h10; a_size[0] = 3'd2;
    a_source[0] = 2'd1; a_mask[0] = 4'hF; a_corrupt[0] = 1'b0; a_valid[0] = 1'b1;
    @(posedge clock);
    #1 a_valid[0] = 1'b0;
    @(negedge clock);
    n_vec++;
    if (d_valid[0] !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_pending got %b need 1", d_valid[0]); end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (d_valid[0] !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_drop got %b need 0", d_valid[0]); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_vec++;
    if (a_ready[0] !== 1'b1 || d_valid[0] !== 1'b0) begin
      n_err++; $display("[TB] FAIL midreset_release got r=%b v=%b need r=1 v=0", a_ready[0], d_valid[0]);
    end
    @(posedge clock); #1;
    do_txn(0, 3'd4, BASE + 30'h10, 3'd2, 2'd2, 4'hF, 32'h0, 1'b0, r, lat);
    n_vec++;
    if (r.data !== 32'hDE22BE44) begin
      n_err++; $display("[TB] FAIL midreset_retained got %h need de22be44", r.data);
    end
  endtask

  task automatic test_random();
    resp_t e, r;
    int lat, idx;
    logic [2:0] op, size;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0] mask;
    logic corr;
    for (int k = 0; k < 16; k++) begin
      data = $urandom;
      model(3'd0, BASE + 30'(4 * k), 3'd2, 2'd0, 4'hF, data, 1'b0, e);
      do_txn(0, 3'd0, BASE + 30'(4 * k), 3'd2, 2'd0, 4'hF, data, 1'b0, r, lat);
      n_vec++;
      if (r !== e) begin n_err++; $display("[TB] FAIL rand_init%0d got %h need %h", k, r, e); end
    end
    for (int t = 0; t < 40; t++) begin
      idx  = int'($urandom_range(0, 15));
      addr = BASE + 30'(4 * idx);
      if ($urandom_range(0, 9) == 0) addr = 30'h0900_0000 + 30'(4 * idx);
      if ($urandom_range(0, 2) == 0) addr = addr + 30'($urandom_range(0, 3));
      size = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: op = 3'd0;
        1: op = 3'd1;
        2, 3: op = 3'd4;
        4: op = 3'd2;
        5: op = 3'd3;
        default: op = 3'd5;
      endcase
      data = $urandom;
      mask = 4'($urandom_range(0, 15));
      corr = ($urandom_range(0, 7) == 0);
      model(op, addr, size, 2'(t), mask, data, corr, e);
      do_txn(0, op, addr, size, 2'(t), mask, data, corr, r, lat);
      n_vec++;
      if (r !== e || lat !== 1) begin
        n_err++;
        $display("[TB] FAIL rand%0d op=%0d addr=%h size=%0d got %h lat=%0d need %h lat=1",
                 t, op, addr, size, r, lat, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0; a_opcode[i] = 3'd0; a_param[i] = 3'd0; a_size[i] = 3'd0;
      a_source[i] = 2'd0; a_address[i] = '0; a_mask[i] = 4'h0; a_data[i] = '0;
      a_corrupt[i] = 1'b0; d_ready[i] = 1'b1;
    end
    test_reset();
    test_put_get();
    test_denied();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
